// File: rtl/hex_result_tx.sv
// Serialises a captured {remainder, quotient} divider result as an ASCII hex line
// "<QUO> <REM><EOL>" over a valid/ready byte stream.
module hex_result_tx #(
  parameter int unsigned WIDTH = 32,
  parameter bit          UPPER = 1'b1,
  parameter bit          CRLF  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] result,
  input  logic             alu_done,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             drop
);

  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned ND = WIDTH / 8;
  localparam int unsigned CW = (ND > 1) ? $clog2(ND) : 1;
  localparam int unsigned SW = CW + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUO,
    S_SP,
    S_REM,
    S_CR,
    S_LF
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic             fire;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] base;
    base = UPPER ? 8'h41 : 8'h61;
    if (n < 4'd10) return 8'h30 + 8'(n);
    else           return base + 8'(n) - 8'd10;
  endfunction

  // Byte offered for a given position in the line; digit k is MSB nibble first.
  function automatic logic [7:0] line_byte(input state_t s, input logic [CW-1:0] k,
                                           input logic [WIDTH-1:0] r);
    logic [HW-1:0] fld;
    logic [SW-1:0] sh;
    logic [3:0]    nib;
    fld = (s == S_REM) ? r[WIDTH-1:HW] : r[HW-1:0];
    sh  = {CW'(ND - 1) - k, 2'b00};
    nib = 4'(fld >> sh);
    case (s)
      S_QUO, S_REM: return hex_ascii(nib);
      S_SP:         return 8'h20;
      S_CR:         return 8'h0D;
      S_LF:         return 8'h0A;
      default:      return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    fire    = tx_valid_q & tx_ready;
    drop_d  = alu_done && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (alu_done) begin
          res_d   = result;
          state_d = S_QUO;
          cnt_d   = '0;
        end
      end
      S_QUO: begin
        if (fire) begin
          if (cnt_q == CW'(ND - 1)) begin
            state_d = S_SP;
            cnt_d   = '0;
          end else begin
            cnt_d = CW'(cnt_q + 1'b1);
          end
        end
      end
      S_SP: begin
        if (fire) state_d = S_REM;
      end
      S_REM: begin
        if (fire) begin
          if (cnt_q == CW'(ND - 1)) begin
            state_d = CRLF ? S_CR : S_LF;
            cnt_d   = '0;
          end else begin
            cnt_d = CW'(cnt_q + 1'b1);
          end
        end
      end
      S_CR: begin
        if (fire) state_d = S_LF;
      end
      S_LF: begin
        if (fire) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are precomputed from next state so they are registered and hold during stalls.
    tx_data_d  = line_byte(state_d, cnt_d, res_d);
    tx_valid_d = (state_d != S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      res_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign drop     = drop_q;

endmodule

// File: tb/tb_hex_result_tx.sv
// Directed bench for hex_result_tx: four parameterisations share clock, reset, strobe
// and ready; each test selects which instance it observes.
module tb_hex_result_tx;

  typedef logic [7:0] bq_t[$];
  typedef logic [8:0] hq_t[$];

  logic        clk;
  logic        rst;
  logic [31:0] result;
  logic [15:0] result16;
  logic        alu_done;
  logic        tx_ready;

  logic [7:0] txd0, txd1, txd2, txd3;
  logic       txv0, txv1, txv2, txv3;
  logic       bsy0, bsy1, bsy2, bsy3;
  logic       drp0, drp1, drp2, drp3;

  int         sel;
  logic [7:0] tx_data_s;
  logic       tx_valid_s, busy_s, drop_s;

  int vecs;
  int errs;

  hex_result_tx #(.WIDTH(32), .UPPER(1'b1), .CRLF(1'b1)) u_main (
    .clk(clk), .rst(rst), .result(result), .alu_done(alu_done), .tx_data(txd0),
    .tx_valid(txv0), .tx_ready(tx_ready), .busy(bsy0), .drop(drp0));
  hex_result_tx #(.WIDTH(32), .UPPER(1'b0), .CRLF(1'b1)) u_lower (
    .clk(clk), .rst(rst), .result(result), .alu_done(alu_done), .tx_data(txd1),
    .tx_valid(txv1), .tx_ready(tx_ready), .busy(bsy1), .drop(drp1));
  hex_result_tx #(.WIDTH(32), .UPPER(1'b1), .CRLF(1'b0)) u_nocrlf (
    .clk(clk), .rst(rst), .result(result), .alu_done(alu_done), .tx_data(txd2),
    .tx_valid(txv2), .tx_ready(tx_ready), .busy(bsy2), .drop(drp2));
  hex_result_tx #(.WIDTH(16), .UPPER(1'b1), .CRLF(1'b1)) u_w16 (
    .clk(clk), .rst(rst), .result(result16), .alu_done(alu_done), .tx_data(txd3),
    .tx_valid(txv3), .tx_ready(tx_ready), .busy(bsy3), .drop(drp3));

  always_comb begin
    case (sel)
      1:       begin tx_data_s = txd1; tx_valid_s = txv1; busy_s = bsy1; drop_s = drp1; end
      2:       begin tx_data_s = txd2; tx_valid_s = txv2; busy_s = bsy2; drop_s = drp2; end
      3:       begin tx_data_s = txd3; tx_valid_s = txv3; busy_s = bsy3; drop_s = drp3; end
      default: begin tx_data_s = txd0; tx_valid_s = txv0; busy_s = bsy0; drop_s = drp0; end
    endcase
  end

  always #5 clk = ~clk;

  function automatic bq_t mk(input string s, input int eol);
    bq_t q;
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    if (eol == 2) q.push_back(8'h0D);
    if (eol >= 1) q.push_back(8'h0A);
    return q;
  endfunction

  task automatic strobe(input logic [31:0] r);
    result   = r;
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
  endtask

  task automatic idle_all();
    alu_done = 1'b0;
    tx_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (!(bsy0 | bsy1 | bsy2 | bsy3)) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Records accepted bytes of the selected instance until busy drops (bounded).
  task automatic collect(input int stall_at, input int stall_len, input int strb_at,
                         input logic [31:0] strb_val, output bq_t q, output hq_t held,
                         output int ncyc, output int ndrop, output bit tmo);
    int stalls;
    bit strobed;
    q = {}; held = {}; ncyc = 0; ndrop = 0; tmo = 1'b1; stalls = 0; strobed = 1'b0;
    for (int c = 0; c < 200; c++) begin
      alu_done = 1'b0;
      if (drop_s) ndrop++;
      if (!busy_s) begin
        tmo = 1'b0;
        break;
      end
      ncyc++;
      if (strb_at >= 0 && !strobed && q.size() == strb_at) begin
        alu_done = 1'b1;
        result   = strb_val;
        strobed  = 1'b1;
      end
      if (stall_at >= 0 && q.size() == stall_at && stalls < stall_len) begin
        tx_ready = 1'b0;
        stalls++;
        held.push_back({tx_valid_s, tx_data_s});
      end else begin
        tx_ready = 1'b1;
      end
      if (tx_valid_s && tx_ready) q.push_back(tx_data_s);
      @(negedge clk);
    end
    alu_done = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    sel = 0;
    repeat (3) @(negedge clk);
    vecs++; if (txd0 !== 8'h00) begin errs++; $display("FAIL reset_tx_data: got %h exp 00", txd0); end
    vecs++; if (txv0 !== 1'b0) begin errs++; $display("FAIL reset_tx_valid: got %b exp 0", txv0); end
    vecs++; if (bsy0 !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b exp 0", bsy0); end
    vecs++; if (drp0 !== 1'b0) begin errs++; $display("FAIL reset_drop: got %b exp 0", drp0); end
    // Strobe coinciding with reset must not start a line.
    result   = 32'h0001_0003;
    alu_done = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    alu_done = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (txv0 !== 1'b0) begin errs++; $display("FAIL rst_strobe_valid: got %b exp 0", txv0); end
    vecs++; if (bsy0 !== 1'b0) begin errs++; $display("FAIL rst_strobe_busy: got %b exp 0", bsy0); end
  endtask

  task automatic test_basic();
    bq_t q, e; hq_t h; int nc, nd; bit tmo;
    sel = 0;
    idle_all();
    e = mk("0003 0001", 2);
    vecs++; if (tx_valid_s !== 1'b0) begin errs++; $display("FAIL t1_pre_valid: got %b exp 0", tx_valid_s); end
    strobe(32'h0001_0003);
    vecs++; if (tx_valid_s !== 1'b1) begin errs++; $display("FAIL t1_latency_valid: got %b exp 1", tx_valid_s); end
    vecs++; if (busy_s !== 1'b1) begin errs++; $display("FAIL t1_latency_busy: got %b exp 1", busy_s); end
    collect(-1, 0, -1, 32'h0, q, h, nc, nd, tmo);
    vecs++; if (tmo !== 1'b0) begin errs++; $display("FAIL t1_timeout: got %b exp 0", tmo); end
    vecs++; if (q.size() != e.size()) begin errs++; $display("FAIL t1_len: got %0d exp %0d", q.size(), e.size()); end
    for (int i = 0; i < e.size(); i++) begin
      vecs++; if (q[i] !== e[i]) begin errs++; $display("FAIL t1_byte%0d: got %h exp %h", i, q[i], e[i]); end
    end
    vecs++; if (nc != 11) begin errs++; $display("FAIL t1_cycles: got %0d exp 11", nc); end
    vecs++; if (busy_s !== 1'b0 || tx_valid_s !== 1'b0)
      begin errs++; $display("FAIL t1_after: got busy=%b valid=%b exp 0 0", busy_s, tx_valid_s); end
  endtask

  task automatic test_case_select();
    bq_t q, e; hq_t h; int nc, nd; bit tmo;
    for (int pass = 0; pass < 2; pass++) begin
      sel = (pass == 0) ? 1 : 0;
      idle_all();
      e = (pass == 0) ? mk("cdef 00ab", 2) : mk("CDEF 00AB", 2);
      strobe(32'h00AB_CDEF);
      collect(-1, 0, -1, 32'h0, q, h, nc, nd, tmo);
      vecs++; if (q.size() != e.size() || tmo)
        begin errs++; $display("FAIL t2_len_sel%0d: got %0d exp %0d", sel, q.size(), e.size()); end
      for (int i = 0; i < e.size(); i++) begin
        vecs++; if (q[i] !== e[i]) begin errs++; $display("FAIL t2_sel%0d_byte%0d: got %h exp %h", sel, i, q[i], e[i]); end
      end
    end
  endtask

  task automatic test_stall();
    bq_t q, e; hq_t h; int nc, nd; bit tmo;
    sel = 0;
    idle_all();
    e = mk("0003 0001", 2);
    strobe(32'h0001_0003);
    collect(2, 5, -1, 32'h0, q, h, nc, nd, tmo);
    vecs++; if (h.size() != 5) begin errs++; $display("FAIL t3_hold_cycles: got %0d exp 5", h.size()); end
    for (int i = 0; i < h.size(); i++) begin
      vecs++; if (h[i] !== 9'h130) begin errs++; $display("FAIL t3_hold%0d: got %h exp 130", i, h[i]); end
    end
    vecs++; if (q.size() != e.size() || tmo)
      begin errs++; $display("FAIL t3_len: got %0d exp %0d", q.size(), e.size()); end
    for (int i = 0; i < e.size(); i++) begin
      vecs++; if (q[i] !== e[i]) begin errs++; $display("FAIL t3_byte%0d: got %h exp %h", i, q[i], e[i]); end
    end
    vecs++; if (nc != 16) begin errs++; $display("FAIL t3_cycles: got %0d exp 16", nc); end
  endtask

  task automatic test_drop();
    bq_t q, e; hq_t h; int nc, nd; bit tmo;
    sel = 0;
    idle_all();
    e = mk("0003 0001", 2);
    strobe(32'h0001_0003);
    collect(-1, 0, 4, 32'h1234_5678, q, h, nc, nd, tmo);
    vecs++; if (nd != 1) begin errs++; $display("FAIL t4_drop_cycles: got %0d exp 1", nd); end
    vecs++; if (q.size() != e.size() || tmo)
      begin errs++; $display("FAIL t4_len: got %0d exp %0d", q.size(), e.size()); end
    for (int i = 0; i < e.size(); i++) begin
      vecs++; if (q[i] !== e[i]) begin errs++; $display("FAIL t4_byte%0d: got %h exp %h", i, q[i], e[i]); end
    end
    repeat (2) @(negedge clk);
    vecs++; if (busy_s !== 1'b0) begin errs++; $display("FAIL t4_no_second_line: got busy=%b exp 0", busy_s); end
    e = mk("5678 1234", 2);
    strobe(32'h1234_5678);
    collect(-1, 0, -1, 32'h0, q, h, nc, nd, tmo);
    vecs++; if (q.size() != e.size() || tmo)
      begin errs++; $display("FAIL t4b_len: got %0d exp %0d", q.size(), e.size()); end
    for (int i = 0; i < e.size(); i++) begin
      vecs++; if (q[i] !== e[i]) begin errs++; $display("FAIL t4b_byte%0d: got %h exp %h", i, q[i], e[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bq_t q, e; hq_t h; int nc, nd; bit tmo;
    sel = 0;
    idle_all();
    strobe(32'h0001_0003);
    collect(-1, 0, 10, 32'hDEAD_BEEF, q, h, nc, nd, tmo);
    vecs++; if (nd != 1) begin errs++; $display("FAIL b2b_lf_drop: got %0d exp 1", nd); end
    vecs++; if (q.size() != 11 || tmo) begin errs++; $display("FAIL b2b_first_len: got %0d exp 11", q.size()); end
    e = mk("0001 FFFF", 2);
    strobe(32'hFFFF_0001);
    collect(-1, 0, -1, 32'h0, q, h, nc, nd, tmo);
    vecs++; if (nc != 11) begin errs++; $display("FAIL b2b_cycles: got %0d exp 11", nc); end
    vecs++; if (q.size() != e.size() || tmo)
      begin errs++; $display("FAIL b2b_len: got %0d exp %0d", q.size(), e.size()); end
    for (int i = 0; i < e.size(); i++) begin
      vecs++; if (q[i] !== e[i]) begin errs++; $display("FAIL b2b_byte%0d: got %h exp %h", i, q[i], e[i]); end
    end
  endtask

  task automatic test_midline_reset();
    bq_t q, e; hq_t h; int nc, nd; bit tmo;
    sel = 0;
    idle_all();
    strobe(32'h0001_0003);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    vecs++; if (tx_valid_s !== 1'b0) begin errs++; $display("FAIL t5_async_valid: got %b exp 0", tx_valid_s); end
    vecs++; if (busy_s !== 1'b0) begin errs++; $display("FAIL t5_async_busy: got %b exp 0", busy_s); end
    vecs++; if (tx_data_s !== 8'h00) begin errs++; $display("FAIL t5_async_data: got %h exp 00", tx_data_s); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (tx_valid_s !== 1'b0) begin errs++; $display("FAIL t5_no_resume: got %b exp 0", tx_valid_s); end
    e = mk("0000 FFFF", 2);
    strobe(32'hFFFF_0000);
    collect(-1, 0, -1, 32'h0, q, h, nc, nd, tmo);
    vecs++; if (q.size() != e.size() || tmo)
      begin errs++; $display("FAIL t5_len: got %0d exp %0d", q.size(), e.size()); end
    for (int i = 0; i < e.size(); i++) begin
      vecs++; if (q[i] !== e[i]) begin errs++; $display("FAIL t5_byte%0d: got %h exp %h", i, q[i], e[i]); end
    end
  endtask

  task automatic test_variants();
    bq_t q, e; hq_t h; int nc, nd; bit tmo;
    sel = 2;
    idle_all();
    e = mk("FFFF 0000", 1);
    strobe(32'h0000_FFFF);
    collect(-1, 0, -1, 32'h0, q, h, nc, nd, tmo);
    vecs++; if (q.size() != 10 || tmo) begin errs++; $display("FAIL t6_lf_len: got %0d exp 10", q.size()); end
    for (int i = 0; i < e.size(); i++) begin
      vecs++; if (q[i] !== e[i]) begin errs++; $display("FAIL t6_lf_byte%0d: got %h exp %h", i, q[i], e[i]); end
    end
    sel = 3;
    idle_all();
    e = mk("05 0A", 2);
    result16 = 16'h0A05;
    strobe(32'h0);
    collect(-1, 0, -1, 32'h0, q, h, nc, nd, tmo);
    vecs++; if (q.size() != 7 || tmo) begin errs++; $display("FAIL t6_w16_len: got %0d exp 7", q.size()); end
    for (int i = 0; i < e.size(); i++) begin
      vecs++; if (q[i] !== e[i]) begin errs++; $display("FAIL t6_w16_byte%0d: got %h exp %h", i, q[i], e[i]); end
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    result   = 32'h0;
    result16 = 16'h0A05;
    alu_done = 1'b0;
    tx_ready = 1'b1;
    sel      = 0;
    vecs     = 0;
    errs     = 0;
    test_reset();
    test_basic();
    test_case_select();
    test_stall();
    test_drop();
    test_back_to_back();
    test_midline_reset();
    test_variants();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
